// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between result producers, issue logic and the register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int NSRC = 3,
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG)
);
  logic [NSRC-1:0]      src_valid;
  logic [NSRC*RW-1:0]   src_rd;
  logic [NSRC*XLEN-1:0] src_data;
  logic [NSRC-1:0]      src_ready;
  logic                 iss_valid;
  logic [RW-1:0]        iss_rd;
  logic                 rf_we;
  logic [RW-1:0]        rf_rd;
  logic [XLEN-1:0]      rf_wd;
  logic [NREG-1:0]      busy;

  // Producer / issue side.
  modport master (
    output src_valid, src_rd, src_data, iss_valid, iss_rd,
    input  src_ready, rf_we, rf_rd, rf_wd, busy
  );

  // Arbiter side.
  modport slave (
    input  src_valid, src_rd, src_data, iss_valid, iss_rd,
    output src_ready, rf_we, rf_rd, rf_wd, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter driving the register-file write port, with a
// per-register busy scoreboard for RAW hazard detection at issue.
module regfile_wb_arbiter #(
  parameter int NSRC = 3,
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int RW = $clog2(NREG);
  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [PW-1:0]   r_rr_ptr;
  logic            r_we;
  logic [RW-1:0]   r_rd;
  logic [XLEN-1:0] r_wd;
  logic [NREG-1:0] r_busy;

  logic [RW-1:0]   w_srd [NSRC];
  logic [XLEN-1:0] w_swd [NSRC];
  logic            w_hit;
  logic            w_hs;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_ptr_nxt;
  logic [RW-1:0]   w_rd;
  logic [XLEN-1:0] w_wd;
  logic [NREG-1:0] w_busy_nxt;

  // Unpack the flat source buses into per-source arrays.
  always_comb begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      w_srd[i] = bus.src_rd[i*RW +: RW];
      w_swd[i] = bus.src_data[i*XLEN +: XLEN];
    end
  end

  // Round-robin search starting at r_rr_ptr; first valid source wins.
  always_comb begin
    int unsigned c;
    logic [PW-1:0] c_idx;
    w_hit = 1'b0;
    w_idx = '0;
    c     = 0;
    c_idx = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      c = 32'(r_rr_ptr) + k;
      if (c >= NSRC) c = c - NSRC;
      c_idx = PW'(c);
      if (!w_hit && bus.src_valid[c_idx]) begin
        w_hit = 1'b1;
        w_idx = c_idx;
      end
    end
  end

  // Reset suppresses any grant, so nothing in flight that cycle is consumed.
  always_comb begin
    w_hs          = w_hit & ~rst;
    w_rd          = w_srd[w_idx];
    w_wd          = w_swd[w_idx];
    w_ptr_nxt     = (w_idx == PW'(NSRC-1)) ? '0 : w_idx + 1'b1;
    bus.src_ready = w_hs ? (NSRC'(1) << w_idx) : '0;
  end

  // Scoreboard update: clear the committing register first so a same-cycle issue re-sets it.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_hs && (w_rd != '0)) w_busy_nxt[w_rd] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != '0)) w_busy_nxt[bus.iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Registered write port, round-robin pointer and busy vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_we     <= 1'b0;
      r_rd     <= '0;
      r_wd     <= '0;
      r_busy   <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_hs) begin
        r_rr_ptr <= w_ptr_nxt;
        r_we     <= (w_rd != '0);
        r_rd     <= w_rd;
        r_wd     <= w_wd;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign bus.rf_we = r_we;
  assign bus.rf_rd = r_rd;
  assign bus.rf_wd = r_wd;
  assign bus.busy  = r_busy;
endmodule
